// File: rtl/acc_write_arbiter.sv
// acc_write_arbiter: three-way round-robin arbiter for accumulator writes,
// with single-cycle grants and bounded locked bursts; all outputs registered.
module acc_write_arbiter #(
    parameter int LOCK_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic [2:0] lock,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    input  logic [7:0] wdata2,
    output logic [2:0] gnt,
    output logic       acc_we,
    output logic [7:0] acc_wdata,
    output logic [1:0] owner,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, GRANT, LOCKED} state_t;
    state_t     state_q, state_d;
    logic [2:0] gnt_q, gnt_d;
    logic       we_q, we_d;
    logic [7:0] wdata_q, wdata_d;
    logic [1:0] owner_q, owner_d, ptr_q, ptr_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] c1, c2, win;
    logic [7:0] win_data, own_data;
    function automatic logic [1:0] nxt(input logic [1:0] p);
        return p == 2'd2 ? 2'd0 : p + 2'd1;
    endfunction
    // Search order ptr+1, ptr+2, ptr; only meaningful when |req.
    assign c1       = nxt(ptr_q);
    assign c2       = nxt(c1);
    assign win      = req[c1] ? c1 : req[c2] ? c2 : ptr_q;
    assign win_data = win == 2'd0 ? wdata0 : win == 2'd1 ? wdata1 : wdata2;
    assign own_data = owner_q == 2'd0 ? wdata0 : owner_q == 2'd1 ? wdata1 : wdata2;
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (|req) begin
                state_d = lock[win] ? LOCKED : GRANT;
                gnt_d   = 3'b001 << win;
                we_d    = 1'b1;
                wdata_d = win_data;
                owner_d = win;
                ptr_d   = win;
                cnt_d   = lock[win] ? 4'd1 : 4'd0;
            end
            LOCKED: if (req[owner_q] && lock[owner_q] && cnt_q < 4'(LOCK_MAX)) begin
                wdata_d = own_data;
                cnt_d   = cnt_q + 4'd1;
            end else begin
                state_d = IDLE;
                gnt_d   = 3'b000;
                we_d    = 1'b0;
                owner_d = 2'd3;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 3'b000;
                we_d    = 1'b0;
                owner_d = 2'd3;
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= 3'b000;
            we_q    <= 1'b0;
            wdata_q <= 8'h00;
            owner_q <= 2'd3;
            ptr_q   <= 2'd2;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end
    assign gnt       = gnt_q;
    assign acc_we    = we_q;
    assign acc_wdata = wdata_q;
    assign owner     = owner_q;
    assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_acc_write_arbiter.sv
// tb_acc_write_arbiter: directed vector table, hand-written reset/unlock
// sequences, and randomized traffic checked against a behavioural model.
module tb_acc_write_arbiter;
    localparam int LM = 4;
    logic       clk = 1'b0, rst = 1'b0;
    logic [2:0] req = '0, lock = '0;
    logic [7:0] wd0 = '0, wd1 = '0, wd2 = '0;
    logic [2:0] gnt;
    logic       acc_we, busy;
    logic [7:0] acc_wdata;
    logic [1:0] owner;
    int tests = 0, fails = 0;
    acc_write_arbiter #(.LOCK_MAX(LM)) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock),
        .wdata0(wd0), .wdata1(wd1), .wdata2(wd2),
        .gnt(gnt), .acc_we(acc_we), .acc_wdata(acc_wdata), .owner(owner), .busy(busy)
    );
    always #5 clk = ~clk;
    typedef struct packed {
        logic [2:0] req, lock;
        logic [7:0] w0, w1, w2;
        logic [2:0] gnt;
        logic       we;
        logic [7:0] data;
        logic [1:0] own;
        logic       busy;
    } vec_t;
    // Model: owner index (-1 = none), last winner, beats written in a burst.
    int m_own, m_last, m_beats;
    bit m_lk;
    logic [7:0] m_data;
    task automatic m_reset();
        m_own = -1; m_last = 2; m_beats = 0; m_lk = 0; m_data = 8'h00;
    endtask
    task automatic m_step();
        logic [7:0] w [3];
        w = '{wd0, wd1, wd2};
        if (m_own < 0) begin
            for (int k = 1; k <= 3 && m_own < 0; k++)
                if (req[(m_last + k) % 3]) m_own = (m_last + k) % 3;
            if (m_own >= 0) begin
                m_last = m_own; m_data = w[m_own]; m_lk = lock[m_own]; m_beats = 1;
            end
        end else if (m_lk && req[m_own] && lock[m_own] && m_beats < LM) begin
            m_beats++; m_data = w[m_own];
        end else m_own = -1;
    endtask
    task automatic check(input string name, input logic [2:0] eg, input logic ew,
                         input logic [7:0] ed, input logic [1:0] eo, input logic eb);
        tests++;
        if ({gnt, acc_we, acc_wdata, owner, busy} !== {eg, ew, ed, eo, eb}) begin
            fails++;
            $display("FAIL %s: got gnt=%b we=%b data=%h own=%0d busy=%b, want gnt=%b we=%b data=%h own=%0d busy=%b",
                     name, gnt, acc_we, acc_wdata, owner, busy, eg, ew, ed, eo, eb);
        end
    endtask
    task automatic drive(input logic [2:0] r, l, input logic [7:0] a, b, c);
        @(negedge clk);
        req = r; lock = l; wd0 = a; wd1 = b; wd2 = c;
        @(posedge clk);
        #1;
    endtask
    initial begin
        vec_t v [20];
        v[0]  = '{3'b001, 3'b000, 8'h5A, 8'h00, 8'h00, 3'b001, 1'b1, 8'h5A, 2'd0, 1'b1};
        v[1]  = '{3'b000, 3'b000, 8'h5A, 8'h00, 8'h00, 3'b000, 1'b0, 8'h5A, 2'd3, 1'b0};
        v[2]  = '{3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0, 8'h5A, 2'd3, 1'b0};
        v[3]  = '{3'b101, 3'b000, 8'h11, 8'h00, 8'h22, 3'b100, 1'b1, 8'h22, 2'd2, 1'b1};
        v[4]  = '{3'b000, 3'b000, 8'h11, 8'h00, 8'h22, 3'b000, 1'b0, 8'h22, 2'd3, 1'b0};
        v[5]  = '{3'b111, 3'b000, 8'hA0, 8'hA1, 8'hA2, 3'b001, 1'b1, 8'hA0, 2'd0, 1'b1};
        v[6]  = '{3'b111, 3'b000, 8'hA0, 8'hA1, 8'hA2, 3'b000, 1'b0, 8'hA0, 2'd3, 1'b0};
        v[7]  = '{3'b111, 3'b000, 8'hA0, 8'hA1, 8'hA2, 3'b010, 1'b1, 8'hA1, 2'd1, 1'b1};
        v[8]  = '{3'b111, 3'b000, 8'hA0, 8'hA1, 8'hA2, 3'b000, 1'b0, 8'hA1, 2'd3, 1'b0};
        v[9]  = '{3'b111, 3'b000, 8'hA0, 8'hA1, 8'hA2, 3'b100, 1'b1, 8'hA2, 2'd2, 1'b1};
        v[10] = '{3'b111, 3'b000, 8'hA0, 8'hA1, 8'hA2, 3'b000, 1'b0, 8'hA2, 2'd3, 1'b0};
        v[11] = '{3'b111, 3'b000, 8'hA0, 8'hA1, 8'hA2, 3'b001, 1'b1, 8'hA0, 2'd0, 1'b1};
        v[12] = '{3'b000, 3'b000, 8'hA0, 8'hA1, 8'hA2, 3'b000, 1'b0, 8'hA0, 2'd3, 1'b0};
        v[13] = '{3'b010, 3'b010, 8'h01, 8'h10, 8'h02, 3'b010, 1'b1, 8'h10, 2'd1, 1'b1};
        v[14] = '{3'b010, 3'b010, 8'h55, 8'h11, 8'h66, 3'b010, 1'b1, 8'h11, 2'd1, 1'b1};
        v[15] = '{3'b010, 3'b010, 8'h77, 8'h12, 8'h88, 3'b010, 1'b1, 8'h12, 2'd1, 1'b1};
        v[16] = '{3'b010, 3'b010, 8'h99, 8'h13, 8'hAA, 3'b010, 1'b1, 8'h13, 2'd1, 1'b1};
        v[17] = '{3'b010, 3'b010, 8'h00, 8'h14, 8'h00, 3'b000, 1'b0, 8'h13, 2'd3, 1'b0};
        v[18] = '{3'b010, 3'b010, 8'h00, 8'h15, 8'h00, 3'b010, 1'b1, 8'h15, 2'd1, 1'b1};
        v[19] = '{3'b000, 3'b000, 8'h00, 8'h16, 8'h00, 3'b000, 1'b0, 8'h15, 2'd3, 1'b0};
        #12;
        check("reset_state", 3'b000, 1'b0, 8'h00, 2'd3, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(v[i].req, v[i].lock, v[i].w0, v[i].w1, v[i].w2);
            check($sformatf("vec%0d", i), v[i].gnt, v[i].we, v[i].data, v[i].own, v[i].busy);
        end
        // Reset asserted mid-burst must clear outputs without waiting for a clock.
        drive(3'b010, 3'b010, 8'h00, 8'hE1, 8'h00);
        check("burst_start", 3'b010, 1'b1, 8'hE1, 2'd1, 1'b1);
        @(negedge clk);
        rst = 1'b0; req = 3'b000; lock = 3'b000;
        #1;
        check("async_reset", 3'b000, 1'b0, 8'h00, 2'd3, 1'b0);
        @(posedge clk);
        #1;
        check("reset_hold", 3'b000, 1'b0, 8'h00, 2'd3, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        drive(3'b011, 3'b000, 8'hC0, 8'hC1, 8'h00);
        check("favour0", 3'b001, 1'b1, 8'hC0, 2'd0, 1'b1);
        @(negedge clk);
        rst = 1'b0; req = 3'b000;
        @(negedge clk);
        rst = 1'b1;
        drive(3'b101, 3'b001, 8'h31, 8'h00, 8'h77);
        check("unlock_b1", 3'b001, 1'b1, 8'h31, 2'd0, 1'b1);
        drive(3'b101, 3'b001, 8'h32, 8'h00, 8'h77);
        check("unlock_b2", 3'b001, 1'b1, 8'h32, 2'd0, 1'b1);
        drive(3'b101, 3'b000, 8'h33, 8'h00, 8'h77);
        check("unlock_rel", 3'b000, 1'b0, 8'h32, 2'd3, 1'b0);
        drive(3'b100, 3'b000, 8'h34, 8'h00, 8'h77);
        check("unlock_req2", 3'b100, 1'b1, 8'h77, 2'd2, 1'b1);
        @(negedge clk);
        rst = 1'b0; req = 3'b000; lock = 3'b000;
        m_reset();
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            rst = 1'b1;
            if ($urandom_range(0, 59) == 0) begin
                rst = 1'b0;
                #1;
                m_reset();
                check("rand_reset", 3'b000, 1'b0, 8'h00, 2'd3, 1'b0);
                continue;
            end
            req  = 3'($urandom);
            lock = $urandom_range(0, 3) != 0 ? req : 3'($urandom);
            wd0  = 8'($urandom); wd1 = 8'($urandom); wd2 = 8'($urandom);
            @(posedge clk);
            #1;
            m_step();
            check($sformatf("rand%0d", i), m_own < 0 ? 3'b000 : 3'b001 << m_own, m_own >= 0,
                  m_data, m_own < 0 ? 2'd3 : 2'(m_own), m_own >= 0);
            tests++;
            if (!$onehot0(gnt) || acc_we !== (|gnt)) begin
                fails++;
                $display("FAIL grant_invariant: got gnt=%b we=%b, want onehot0 gnt with we=|gnt", gnt, acc_we);
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/acc_write_arbiter.md
ACC_WRITE_ARBITER -- requirements
Module: acc_write_arbiter

Interface
REQ-001 Parameter LOCK_MAX, default 4, maximum consecutive writes in one locked burst (range 1..15).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 req  input  3  write request per requester: bit0 ALU result, bit1 internal data bus (MOV), bit2 SFR direct write.
REQ-005 lock  input  3  per-requester burst request, meaningful only while the matching req bit is high.
REQ-006 wdata0 / wdata1 / wdata2  input  8 each  write data from requester 0 / 1 / 2.
REQ-007 gnt  output  3  one-hot grant, registered; 3'b000 when no owner.
REQ-008 acc_we  output  1  accumulator write enable, registered; drives the accumulator register set_acc input.
REQ-009 acc_wdata  output  8  accumulator write data, registered; drives the accumulator register value input.
REQ-010 owner  output  2  encoded current owner 0/1/2; 2'b11 when none.
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 The arbiter SHALL implement the three states IDLE, GRANT and LOCKED, with all outputs registered.
REQ-013 A round-robin pointer SHALL hold the last granted index; the search order SHALL be ptr+1, ptr+2, ptr+3 (mod 3).
REQ-014 In IDLE with req == 0: gnt=000, acc_we=0, owner=11, acc_wdata holds its previous value.
REQ-015 In IDLE with any req bit high at edge N: the winner w SHALL take effect at edge N, giving gnt=onehot(w), acc_we=1, acc_wdata=wdata_w, owner=w and ptr=w.
REQ-016 Latency SHALL be one cycle from req sampled to gnt/acc_we visible.
REQ-017 If lock[w] is low at the winning edge: next state GRANT, and the beat counter is not used.
REQ-018 If lock[w] is high at the winning edge: next state LOCKED, with beat counter = 1.
REQ-019 GRANT SHALL last exactly one cycle: the next edge clears gnt, acc_we and owner, returns to IDLE, and ignores req.
REQ-020 In GRANT, unlocked throughput SHALL be at most one write every two cycles.
REQ-021 The granted requester SHALL hold req and wdata until it sees gnt, then deassert req before the end of the GRANT cycle.
REQ-022 In LOCKED, at each edge with req[owner] & lock[owner] and beat counter < LOCK_MAX: acc_we=1, acc_wdata=wdata_owner, gnt held, and the counter increments.
REQ-023 In LOCKED, if req[owner]=0, lock[owner]=0, or the counter = LOCK_MAX: gnt=000, acc_we=0, owner=11, next state IDLE, and no write occurs on that edge.
REQ-024 A forced release at LOCK_MAX SHALL leave ptr=owner, so other pending requesters win next.
REQ-025 Requests from non-owners SHALL be ignored in GRANT and LOCKED; they are not queued, and requesters keep req high.
REQ-026 The arbiter SHALL never assert more than one gnt bit, and acc_we SHALL equal |gnt in every cycle.
REQ-027 Changes to wdata of a non-owner SHALL have no effect on acc_wdata.

Reset
REQ-028 rst=0 SHALL immediately force state=IDLE, gnt=000, acc_we=0, acc_wdata=8'h00, owner=11, busy=0, beat counter=0 and ptr=2, independent of clk.
REQ-029 Reset mid-GRANT or mid-LOCKED SHALL abort the write with no further acc_we pulse.
REQ-030 After release of reset, the first arbitration SHALL favour requester 0.

Verification
REQ-031 Reset: assert rst=0 during a LOCKED burst -> same-cycle gnt=000, acc_we=0, acc_wdata=00, owner=11, busy=0.
REQ-032 Single write: req=001, wdata0=8'h5A -> next cycle gnt=001, acc_we=1, acc_wdata=5A for one cycle, then one idle cycle.
REQ-033 Round-robin: req=111 held, lock=000 -> gnt sequence 001, 000, 010, 000, 100, 000, 001.
REQ-034 Priority after history: last grant to 0, then req=101 -> gnt=100 (requester 2 wins).
REQ-035 Burst limit: LOCK_MAX=4; req=010 and lock=010 held 8 cycles; wdata1 = 10,11,12,13,... per cycle -> 4 consecutive writes 10,11,12,13, then one cycle acc_we=0, then requester 1 re-granted.
REQ-036 Early unlock: 2-beat burst from requester 0 with lock dropped on the third edge -> exactly 2 writes, then IDLE, then pending req2 granted.
